// File: rtl/scan_chain_ctrl_if.sv
// Pattern handshake bundle between a pattern source (master) and scan_chain_ctrl (slave).
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 16
);
    logic                 pat_valid;
    logic                 pat_ready;
    logic [CHAIN_LEN-1:0] pat_data;
    logic [CHAIN_LEN-1:0] exp_data;

    modport master (output pat_valid, output pat_data, output exp_data, input pat_ready);
    modport slave  (input pat_valid, input pat_data, input exp_data, output pat_ready);
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan chain load/unload sequencer with response compare and sticky fail counting.
// Optional response MISR on `signature` is built only when SCAN_CTRL_MISR_EN is defined.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    scan_chain_ctrl_if.slave pat_if,
    output logic             SE,
    output logic             SI,
    input  logic             SO,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] fail_count,
    output logic [15:0]      signature
);
    localparam int BCW = $clog2(CHAIN_LEN) + 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_PAT, S_SHIFT, S_CAPTURE, S_FLUSH, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 se_q, se_d, si_q, si_d;
    logic [CHAIN_LEN-1:0] stim_q, stim_d, exp_cur_q, exp_cur_d, cmp_q, cmp_d;
    logic [CNT_W-1:0]     num_pat_q, num_pat_d, pat_cnt_q, pat_cnt_d;
    logic [CNT_W-1:0]     fail_count_q, fail_count_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 have_prev_q, have_prev_d, fail_q, fail_d;
    logic                 start_acc, last_bit, more_pat, cmp_en, mismatch;

    assign start_acc = (state_q == S_IDLE) && start;
    assign last_bit  = (bit_cnt_q == LAST_BIT);
    assign more_pat  = (pat_cnt_q + CNT_W'(1)) != num_pat_q;
    // First pattern's unload is still the chain's power-up content, so it is not judged.
    assign cmp_en    = ((state_q == S_SHIFT) && have_prev_q) || (state_q == S_FLUSH);
    assign mismatch  = cmp_en && (SO != cmp_q[0]);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = (num_pat == '0) ? S_DONE : S_WAIT_PAT;
            S_WAIT_PAT: if (pat_if.pat_valid) state_d = S_SHIFT;
            S_SHIFT:    if (last_bit) state_d = S_CAPTURE;
            S_CAPTURE:  state_d = more_pat ? S_WAIT_PAT : S_FLUSH;
            S_FLUSH:    if (last_bit) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // SE/SI are registered from the upcoming state so the chain sees clean flop outputs.
    always_comb begin
        pat_if.pat_ready = (state_q == S_WAIT_PAT);
        busy             = (state_q != S_IDLE);
        done             = (state_q == S_DONE);
        se_d = (state_d == S_WAIT_PAT) || (state_d == S_SHIFT) || (state_d == S_FLUSH);
        si_d = 1'b0;
        if (state_d == S_SHIFT)
            si_d = (state_q == S_WAIT_PAT) ? pat_if.pat_data[0] : stim_q[0];
    end

    always_comb begin
        stim_d       = stim_q;
        exp_cur_d    = exp_cur_q;
        cmp_d        = cmp_q;
        num_pat_d    = num_pat_q;
        pat_cnt_d    = pat_cnt_q;
        have_prev_d  = have_prev_q;
        fail_d       = fail_q;
        fail_count_d = fail_count_q;
        bit_cnt_d    = '0;
        if (((state_q == S_SHIFT) && (state_d == S_SHIFT)) ||
            ((state_q == S_FLUSH) && (state_d == S_FLUSH)))
            bit_cnt_d = bit_cnt_q + BCW'(1);
        case (state_q)
            S_IDLE: if (start) begin
                num_pat_d    = num_pat;
                pat_cnt_d    = '0;
                have_prev_d  = 1'b0;
                fail_d       = 1'b0;
                fail_count_d = '0;
            end
            S_WAIT_PAT: if (pat_if.pat_valid) begin
                stim_d    = pat_if.pat_data >> 1;
                exp_cur_d = pat_if.exp_data;
                cmp_d     = exp_cur_q;
            end
            S_SHIFT, S_FLUSH: begin
                stim_d = stim_q >> 1;
                cmp_d  = cmp_q >> 1;
            end
            S_CAPTURE: begin
                pat_cnt_d   = pat_cnt_q + CNT_W'(1);
                have_prev_d = 1'b1;
                cmp_d       = exp_cur_q;
            end
            default: ;
        endcase
        if (mismatch) begin
            fail_d = 1'b1;
            if (fail_count_q != '1) fail_count_d = fail_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            se_q         <= 1'b0;
            si_q         <= 1'b0;
            stim_q       <= '0;
            exp_cur_q    <= '0;
            cmp_q        <= '0;
            num_pat_q    <= '0;
            pat_cnt_q    <= '0;
            have_prev_q  <= 1'b0;
            fail_q       <= 1'b0;
            fail_count_q <= '0;
            bit_cnt_q    <= '0;
        end else begin
            se_q         <= se_d;
            si_q         <= si_d;
            stim_q       <= stim_d;
            exp_cur_q    <= exp_cur_d;
            cmp_q        <= cmp_d;
            num_pat_q    <= num_pat_d;
            pat_cnt_q    <= pat_cnt_d;
            have_prev_q  <= have_prev_d;
            fail_q       <= fail_d;
            fail_count_q <= fail_count_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    assign SE         = se_q;
    assign SI         = si_q;
    assign fail       = fail_q;
    assign fail_count = fail_count_q;

`ifdef SCAN_CTRL_MISR_EN
    logic [15:0] misr_q, misr_d;

    // x^16+x^12+x^3+x+1, SO folded into bit 0; only compare cycles advance it.
    always_comb begin
        misr_d = misr_q;
        if (start_acc)
            misr_d = '0;
        else if (cmp_en)
            misr_d = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h100B : 16'h0000) ^ {15'b0, SO};
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) misr_q <= '0;
        else     misr_q <= misr_d;
    end

    assign signature = misr_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign signature        = '0;
`endif
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl: loopback chain model, handshake stalls, reset, saturation.
module tb_scan_chain_ctrl;
    localparam int CL = 16;
    localparam int CW = 8;

    logic          CK = 1'b0;
    logic          RN = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_pat = '0;
    logic          SE, SI, SO, busy, done, fail;
    logic [CW-1:0] fail_count;
    logic [15:0]   signature;

    scan_chain_ctrl_if #(.CHAIN_LEN(CL)) pif ();

    scan_chain_ctrl #(.CHAIN_LEN(CL), .CNT_W(CW)) dut (
        .CK(CK), .RN(RN), .start(start), .num_pat(num_pat), .pat_if(pif.slave),
        .SE(SE), .SI(SI), .SO(SO), .busy(busy), .done(done), .fail(fail),
        .fail_count(fail_count), .signature(signature)
    );

    always #5 CK = ~CK;

    // Loopback chain: scan clock gated while the controller waits for a pattern; capture holds.
    logic [CL-1:0] chain = '0;
    logic          so_inv = 1'b0;
    always @(posedge CK) if (SE && !pif.pat_ready) chain <= {chain[CL-2:0], SI};
    assign SO = chain[CL-1] ^ so_inv;

    logic [CL-1:0] pat_mem [32];
    logic [CL-1:0] exp_mem [32];
    int vec = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] golden_sig(input int npat);
        logic [15:0] m;
        m = '0;
`ifdef SCAN_CTRL_MISR_EN
        for (int p = 0; p < npat; p++)
            for (int k = 0; k < CL; k++)
                m = {m[14:0], 1'b0} ^ (m[15] ? 16'h100B : 16'h0000) ^ {15'b0, pat_mem[p][k] ^ so_inv};
`endif
        return m;
    endfunction

    function automatic int golden_fails(input int npat);
        int n;
        n = 0;
        for (int p = 0; p < npat; p++)
            for (int k = 0; k < CL; k++)
                if ((pat_mem[p][k] ^ so_inv) != exp_mem[p][k]) n++;
        return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
    endfunction

    task automatic run(input string tag, input int npat, input int stall_idx, input int stall_len,
                       input bit ign_start, input int abort_at);
        int cycles, idx, stalled, exp_cycles;
        bit xfer, se_seen;
        pif.pat_valid = 1'b0;
        num_pat = CW'(npat);
        start = 1'b1;
        @(posedge CK); #1;
        start = ign_start;
        if (ign_start) num_pat = '0;
        cycles = 1; idx = 0; stalled = 0; se_seen = SE;
        while (!done && cycles < 400 && !(abort_at > 0 && cycles == abort_at)) begin
            pif.pat_data  = pat_mem[idx];
            pif.exp_data  = exp_mem[idx];
            pif.pat_valid = (idx < npat);
            if (pif.pat_ready && idx == stall_idx && stalled < stall_len) begin
                pif.pat_valid = 1'b0;
                stalled++;
                chk({tag, " stall SE"}, SE, 1);
                chk({tag, " stall SI"}, SI, 0);
            end
            xfer = pif.pat_valid && pif.pat_ready;
            @(posedge CK); #1;
            cycles++;
            if (xfer) idx++;
            se_seen |= SE;
        end
        start = 1'b0;
        pif.pat_valid = 1'b0;
        if (abort_at > 0) return;
        exp_cycles = (npat == 0) ? 1 : 1 + npat * (CL + 2) + CL + stall_len;
        chk({tag, " done seen"}, done, 1);
        chk({tag, " cycles"}, cycles, exp_cycles);
        chk({tag, " busy@done"}, busy, 1);
        chk({tag, " fail"}, fail, (golden_fails(npat) != 0));
        chk({tag, " fail_count"}, fail_count, golden_fails(npat));
        chk({tag, " signature"}, signature, golden_sig(npat));
        if (npat == 0) chk({tag, " SE never"}, se_seen, 0);
        @(posedge CK); #1;
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " idle busy"}, busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " SE"}, SE, 0);
        chk({tag, " SI"}, SI, 0);
        chk({tag, " pat_ready"}, pif.pat_ready, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " fail"}, fail, 0);
        chk({tag, " fail_count"}, fail_count, 0);
        chk({tag, " signature"}, signature, 0);
    endtask

    initial begin
        pif.pat_valid = 1'b0;
        pif.pat_data  = '0;
        pif.exp_data  = '0;
        for (int i = 0; i < 32; i++) begin
            pat_mem[i] = '0;
            exp_mem[i] = '0;
        end
        #12;
        chk_reset_vals("reset");
        @(negedge CK) RN = 1'b1;
        @(posedge CK); #1;

        run("zero", 0, -1, 0, 1'b0, 0);

        pat_mem[0] = 16'hA5C3; pat_mem[1] = 16'h1E7F; pat_mem[2] = 16'h8001;
        for (int i = 0; i < 3; i++) exp_mem[i] = pat_mem[i];
        run("two", 2, -1, 0, 1'b0, 0);

        exp_mem[0] = pat_mem[0] ^ 16'h0008;
        run("bit3", 2, -1, 0, 1'b0, 0);
        exp_mem[0] = pat_mem[0];

        exp_mem[1] = pat_mem[1] ^ 16'h0100;
        exp_mem[2] = pat_mem[2] ^ 16'h8001;
        run("edges", 3, -1, 0, 1'b0, 0);
        exp_mem[1] = pat_mem[1];
        exp_mem[2] = pat_mem[2];

        run("stall", 3, 1, 5, 1'b1, 0);

        so_inv = 1'b1;
        run("abort", 2, -1, 0, 1'b0, 26);
        chk("abort pre SE", SE, 1);
        chk("abort pre fail", fail, 1);
        #3 RN = 1'b0;
        #1 chk_reset_vals("midrst");
        so_inv = 1'b0;
        @(negedge CK) RN = 1'b1;
        @(posedge CK); #1;
        chk("midrst no done", done, 0);
        run("post_rst", 2, -1, 0, 1'b0, 0);

        for (int i = 0; i < 19; i++) begin
            pat_mem[i] = CL'(16'h1357 * (i + 1)) ^ CL'(16'hC0DE);
            exp_mem[i] = pat_mem[i];
        end
        so_inv = 1'b1;
        run("sat", 19, -1, 0, 1'b0, 0);
        so_inv = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 16: number of scan cells in the driven chain (2..256).
REQ-002 Parameter CNT_W, default 8: width of the pattern count and fail count.
REQ-003 CK  input  1  clock; all state updates on rising edge. One clock; reset is asynchronous and active-low.
REQ-004 RN  input  1  asynchronous active-low reset.
REQ-005 start  input  1  pulse in IDLE begins a test run.
REQ-006 num_pat  input  CNT_W  pattern count; sampled when start is accepted; 0 means an empty run.
REQ-007 pat_valid / pat_ready  input / output  1 / 1  pattern handshake; a transfer occurs when both are high on a CK edge.
REQ-008 pat_data  input  CHAIN_LEN  stimulus; bit 0 is shifted first.
REQ-009 exp_data  input  CHAIN_LEN  expected capture response of the same pattern; bit k is compared with the k-th unloaded bit.
REQ-010 SE  output  1  scan enable to the chain.
REQ-011 SI  output  1  scan input to the first cell.
REQ-012 SO  input  1  scan output of the last cell.
REQ-013 busy, done, fail  output  1 each  run active / one-cycle completion pulse / sticky mismatch flag.
REQ-014 fail_count  output  CNT_W  count of mismatching bits; saturates at all-ones.
REQ-015 signature  output  16  response signature (see Configuration).

Function
REQ-016 States: IDLE, WAIT_PAT, SHIFT, CAPTURE, FLUSH, DONE.
REQ-017 IDLE: SE=0, SI=0, pat_ready=0; start=1 latches num_pat, clears fail, fail_count and signature, and moves to WAIT_PAT, or to DONE if num_pat=0.
REQ-018 WAIT_PAT: pat_ready=1, SE=1; on transfer, load the stimulus register from pat_data, load the expected register from exp_data (keeping the previous expected value for unload), then go to SHIFT.
REQ-019 SHIFT: exactly CHAIN_LEN cycles with SE=1; SI presents stimulus bit k in shift cycle k (k=0..CHAIN_LEN-1), and SO is sampled on the same CK edge.
REQ-020 In SHIFT, the unloaded bit k is compared with previous-expected bit k; no compare is made during the first pattern's shift.
REQ-021 After SHIFT, CAPTURE holds SE=0 for exactly one cycle, then increments the pattern counter.
REQ-022 After CAPTURE, go to WAIT_PAT if more patterns remain, else to FLUSH.
REQ-023 FLUSH: CHAIN_LEN cycles with SE=1 and SI=0, comparing SO with the last pattern's expected bits; then go to DONE.
REQ-024 DONE: done=1 for one cycle, then IDLE.
REQ-025 Every mismatch sets fail and increments fail_count; fail_count holds at 2^CNT_W-1.
REQ-026 busy=1 in every state except IDLE.
REQ-027 start outside IDLE is ignored.
REQ-028 A pat_valid stall in WAIT_PAT holds SE=1 and SI stable, with no shift counting.
REQ-029 A single bit counter of width ceil(log2(CHAIN_LEN))+1 counts SHIFT and FLUSH cycles; it wraps to 0 at each state entry.
REQ-030 SE and SI are driven directly from flops (no combinational path from inputs).

Reset
REQ-031 RN low asynchronously forces IDLE, SE=0, SI=0, pat_ready=0, busy=0, done=0, fail=0, fail_count=0, signature=0, and clears all counters.
REQ-032 Reset mid-run abandons the run with no done pulse; the next run starts clean.

Configuration
REQ-033 Macro SCAN_CTRL_MISR_EN defined: signature is a 16-bit MISR (polynomial x^16+x^12+x^3+x+1) clocked with SO on every compare cycle; it is cleared on start and frozen in DONE/IDLE.
REQ-034 Macro SCAN_CTRL_MISR_EN undefined: signature is tied to 0 and no MISR logic is built; all other behaviour is identical.

Verification
REQ-035 CHAIN_LEN=16, loopback SO=SI through a 16-stage shift model with capture = hold, num_pat=2 with exp_data equal to each pat_data -> fail=0, fail_count=0, done pulse after 2*(16+1)+16 plus handshake cycles.
REQ-036 Same setup with exp_data bit 3 of pattern 1 inverted -> fail=1, fail_count=1.
REQ-037 num_pat=0 -> busy for one cycle, done pulse, no SE assertion.
REQ-038 pat_valid held low for 5 cycles in WAIT_PAT -> SE stays 1, SI stable, and the shift count is unaffected.
REQ-039 RN pulsed low mid-SHIFT -> all outputs return to reset values immediately, and a new start completes a correct run.
REQ-040 SO forced to inverse of model for 300 bits with CNT_W=8 -> fail_count saturates at 255; with SCAN_CTRL_MISR_EN, signature matches the golden-model MISR value.
